// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage control and the ALU.
// The master drives operands and the operation select; the ALU drives the result.
interface alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUOp;
    logic [31:0] C;

    modport master (
        output A,
        output B,
        output ALUOp,
        input  C
    );

    modport slave (
        input  A,
        input  B,
        input  ALUOp,
        output C
    );
endinterface

// File: rtl/alu.sv
// Execute-stage 32-bit ALU: combinational result selection feeding one result register.
// The result appears on C one rising clock edge after the operands are sampled.
module alu (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SRL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_SLT  = 3'b110,
        OP_SLTU = 3'b111
    } aluOp_t;

    aluOp_t      w_op;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic [31:0] r_result;

    assign w_op    = aluOp_t'(bus.ALUOp);
    // Only the low five bits of B select a shift distance; the rest is ignored.
    assign w_shamt = bus.B[4:0];

    always_comb begin
        w_result = 32'h0000_0000;
        unique case (w_op)
            OP_ADD:  w_result = bus.A + bus.B;
            OP_SUB:  w_result = bus.A - bus.B;
            OP_AND:  w_result = bus.A & bus.B;
            OP_OR:   w_result = bus.A | bus.B;
            OP_SRL:  w_result = bus.A >> w_shamt;
            OP_SRA:  w_result = $unsigned($signed(bus.A) >>> w_shamt);
            OP_SLT:  w_result = {31'd0, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: w_result = {31'd0, (bus.A < bus.B)};
            default: w_result = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= 32'h0000_0000;
        end else begin
            r_result <= w_result;
        end
    end

    assign bus.C = r_result;

endmodule

// File: tb/tb_alu.sv
// Randomised and directed bench for alu against an arithmetic reference model.
module tb_alu;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: shifts as powers-of-two division, compares on widened integers.
    function automatic logic [31:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint div;
        longint q;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = a[31] ? (ua - 64'sh1_0000_0000) : ua;
        sb  = b[31] ? (ub - 64'sh1_0000_0000) : ub;
        div = longint'(1) << (b % 32);
        case (op)
            3'd0: refModel = 32'((ua + ub) % 64'sh1_0000_0000);
            3'd1: refModel = 32'((ua - ub + 64'sh1_0000_0000) % 64'sh1_0000_0000);
            3'd2: refModel = a & b;
            3'd3: refModel = a | b;
            3'd4: refModel = 32'(ua / div);
            3'd5: begin
                if (sa >= 0) q = sa / div;
                else         q = (sa - (div - 1)) / div;
                refModel = 32'(q);
            end
            3'd6: refModel = (sa < sb) ? 32'd1 : 32'd0;
            default: refModel = (ua < ub) ? 32'd1 : 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total = total + 1;
        if (observed !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
        end
    endtask

    // Drive operands away from the active edge, then sample just after it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
        @(negedge clk);
        bus.A     = a;
        bus.B     = b;
        bus.ALUOp = op;
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [31:0] expected);
        applyStimulus(a, b, op);
        checkOutput(tag, bus.C, expected);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] held;

        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.A     = 32'h1234_5678;
        bus.B     = 32'h0000_0001;
        bus.ALUOp = 3'b000;

        #2;
        checkOutput("reset_no_edge", bus.C, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", bus.C, 32'h0);

        @(negedge clk);
        reset = 1'b0;

        runOp("add_1_0",      32'h1,          32'h0,          3'b000, 32'h1);
        runOp("add_wrap",     32'hFFFF_FFFF,  32'h1,          3'b000, 32'h0);
        runOp("sub_5_7",      32'd5,          32'd7,          3'b001, 32'hFFFF_FFFE);
        runOp("and",          32'hF0F0_F0F0,  32'hFF00_FF00,  3'b010, 32'hF000_F000);
        runOp("or",           32'hF0F0_F0F0,  32'hFF00_FF00,  3'b011, 32'hFFF0_FFF0);
        runOp("srl_4",        32'h8000_0010,  32'd4,          3'b100, 32'h0800_0001);
        runOp("sra_4",        32'h8000_0010,  32'd4,          3'b101, 32'hF800_0001);
        runOp("srl_b_hi_ign", 32'h8000_0010,  32'h0000_0024,  3'b100, 32'h0800_0001);
        runOp("sra_0",        32'h8000_0010,  32'd0,          3'b101, 32'h8000_0010);
        runOp("sra_31",       32'h8000_0000,  32'd31,         3'b101, 32'hFFFF_FFFF);
        runOp("srl_31",       32'h8000_0000,  32'd31,         3'b100, 32'h0000_0001);
        runOp("slt_neg",      32'hFFFF_FFFF,  32'd1,          3'b110, 32'h1);
        runOp("sltu_big",     32'hFFFF_FFFF,  32'd1,          3'b111, 32'h0);
        runOp("slt_eq",       32'd3,          32'd3,          3'b110, 32'h0);
        runOp("sltu_less",    32'd1,          32'hFFFF_FFFF,  3'b111, 32'h1);

        // Mid-cycle input change must not reach C before the next edge.
        runOp("latency_pre",  32'd100,        32'd23,         3'b000, 32'd123);
        @(negedge clk);
        bus.A     = 32'd40;
        bus.B     = 32'd2;
        bus.ALUOp = 3'b001;
        #2;
        checkOutput("latency_hold", bus.C, 32'd123);
        @(posedge clk);
        #1;
        checkOutput("latency_update", bus.C, 32'd38);

        // Asynchronous reset between edges while C is nonzero.
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("async_reset", bus.C, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset_wins", bus.C, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", bus.C, 32'd38);

        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 3'($urandom_range(0, 7));
            if ((i % 4) == 0) b = 32'($urandom_range(0, 40));
            if ((i % 7) == 0) a = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            applyStimulus(a, b, op);
            checkOutput($sformatf("rand_op%0d", op), bus.C, refModel(a, b, op));
        end

        held = bus.C;
        @(negedge clk);
        bus.A = ~bus.A;
        #2;
        checkOutput("rand_hold", bus.C, held);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
